// File: rtl/genius_led_if.sv
// Game-side bus of the GENIUS LED player: start/length request, sequence memory read,
// colour LEDs, status and player key pulses. Names are from the player's point of view.
interface genius_led_if;
  logic       i_start;
  logic [5:0] i_len;
  logic [4:0] o_seq_addr;
  logic [1:0] i_seq_data;
  logic       o_led0, o_led1, o_led2, o_led3;
  logic       o_busy;
  logic       o_done;
  logic       i_btn0, i_btn1, i_btn2, i_btn3;

  modport master (
    output i_start, i_len, i_seq_data, i_btn0, i_btn1, i_btn2, i_btn3,
    input  o_seq_addr, o_led0, o_led1, o_led2, o_led3, o_busy, o_done
  );
  modport slave (
    input  i_start, i_len, i_seq_data, i_btn0, i_btn1, i_btn2, i_btn3,
    output o_seq_addr, o_led0, o_led1, o_led2, o_led3, o_busy, o_done
  );
endinterface

// File: rtl/genius_led_player.sv
// Replays the stored colour sequence on four LEDs with fixed on/off timing.
// Optional GENIUS_LED_ECHO_EN: in IDLE a player key pulse lights its LED for ON_CYCLES.
module genius_led_player #(
  parameter int MAX_LEN    = 32,
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 12500000,
  parameter int CNT_W      = 25
) (
  input  logic         i_clk,
  input  logic         i_rst,
  genius_led_if.slave  bus
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ON, S_OFF, S_FIN, S_ECHO} state_t;

  localparam logic [6:0]       LEN_MAX = 7'(MAX_LEN);
  localparam logic [CNT_W-1:0] ON_LD   = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LD  = CNT_W'(OFF_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [5:0]       r_len, w_len_nxt;
  logic [4:0]       r_idx, w_idx_nxt;
  logic [1:0]       r_colour, w_colour_nxt;
  logic [CNT_W-1:0] r_timer, w_timer_nxt;
  logic [3:0]       r_led, w_led_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  logic [5:0] w_len_clamped;
  logic       w_last;
  logic [3:0] w_btn;
  logic       w_btn_any;
  logic [1:0] w_btn_sel;

  assign w_len_clamped = ({1'b0, bus.i_len} > LEN_MAX) ? LEN_MAX[5:0] : bus.i_len;
  assign w_last        = ({1'b0, r_idx} == (r_len - 6'd1));
  assign w_btn         = ~{bus.i_btn3, bus.i_btn2, bus.i_btn1, bus.i_btn0};
  assign w_btn_any     = |w_btn;

  // Simultaneous key pulses: the lowest index wins.
  always_comb begin
    w_btn_sel = 2'd0;
    if      (w_btn[0]) w_btn_sel = 2'd0;
    else if (w_btn[1]) w_btn_sel = 2'd1;
    else if (w_btn[2]) w_btn_sel = 2'd2;
    else if (w_btn[3]) w_btn_sel = 2'd3;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_len_nxt    = r_len;
    w_idx_nxt    = r_idx;
    w_colour_nxt = r_colour;
    w_timer_nxt  = r_timer;
    case (r_state)
      S_IDLE, S_ECHO: begin
        if (bus.i_start) begin
          if (bus.i_len != 6'd0) begin
            w_state_nxt = S_FETCH;
            w_len_nxt   = w_len_clamped;
            w_idx_nxt   = 5'd0;
          end else begin
            w_state_nxt = S_FIN;
          end
`ifdef GENIUS_LED_ECHO_EN
        end else if (w_btn_any) begin
          w_state_nxt  = S_ECHO;
          w_colour_nxt = w_btn_sel;
          w_timer_nxt  = ON_LD;
        end else if (r_state == S_ECHO) begin
          if (r_timer == '0) w_state_nxt = S_IDLE;
          else               w_timer_nxt = r_timer - 1'b1;
`endif
        end
      end
      S_FETCH: begin
        w_colour_nxt = bus.i_seq_data;
        w_timer_nxt  = ON_LD;
        w_state_nxt  = S_ON;
      end
      S_ON: begin
        if (r_timer == '0) begin
          w_timer_nxt = OFF_LD;
          w_state_nxt = S_OFF;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      S_OFF: begin
        if (r_timer == '0) begin
          if (w_last) begin
            w_state_nxt = S_FIN;
          end else begin
            w_idx_nxt   = r_idx + 5'd1;
            w_state_nxt = S_FETCH;
          end
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    w_led_nxt  = 4'd0;
    w_busy_nxt = (w_state_nxt == S_FETCH) || (w_state_nxt == S_ON) || (w_state_nxt == S_OFF);
    w_done_nxt = (w_state_nxt == S_FIN);
    if ((w_state_nxt == S_ON) || (w_state_nxt == S_ECHO))
      w_led_nxt = 4'd1 << w_colour_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_len    <= 6'd0;
      r_idx    <= 5'd0;
      r_colour <= 2'd0;
      r_timer  <= '0;
      r_led    <= 4'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_len    <= w_len_nxt;
      r_idx    <= w_idx_nxt;
      r_colour <= w_colour_nxt;
      r_timer  <= w_timer_nxt;
      r_led    <= w_led_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign bus.o_seq_addr = r_idx;
  assign bus.o_led0     = r_led[0];
  assign bus.o_led1     = r_led[1];
  assign bus.o_led2     = r_led[2];
  assign bus.o_led3     = r_led[3];
  assign bus.o_busy     = r_busy;
  assign bus.o_done     = r_done;
endmodule

// File: tb/tb_genius_led_player.sv
// Directed bench for genius_led_player with ON=4, OFF=2 (7-cycle steps).
module tb_genius_led_player;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [1:0] mem [32];

  genius_led_if bus();

  genius_led_player #(.MAX_LEN(32), .ON_CYCLES(4), .OFF_CYCLES(2), .CNT_W(25)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  assign bus.i_seq_data = mem[bus.o_seq_addr];

  wire [3:0] led = {bus.o_led3, bus.o_led2, bus.o_led1, bus.o_led0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_start = 1'b1;
    bus.i_len = 6'd3;
    tick(); tick();
    rst = 1'b0;
    bus.i_start = 1'b0;
    tests++; if (led !== 4'd0) begin fails++; $display("FAIL reset_led got=%b exp=0000", led); end
    tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
    tests++; if (bus.o_done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", bus.o_done); end
    tests++; if (bus.o_seq_addr !== 5'd0) begin fails++; $display("FAIL reset_addr got=%0d exp=0", bus.o_seq_addr); end
    tick();
    tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL rst_beats_start busy got=%b exp=0", bus.o_busy); end
  endtask

  task automatic test_play3();
    logic [1:0] col [3];
    logic [3:0] e_led;
    logic       e_busy, e_done;
    int s, p;
    col[0] = 2'd2; col[1] = 2'd0; col[2] = 2'd3;
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
    bus.i_start = 1'b1; bus.i_len = 6'd3;
    tick();
    bus.i_start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      if (k == 3) mem[0] = 2'd1;  // memory change mid-step must not affect the lit LED
      s = (k - 1) / 7; p = (k - 1) % 7;
      e_led = 4'd0; e_busy = 1'b0; e_done = 1'b0;
      if (k <= 21) begin
        e_busy = 1'b1;
        if (p >= 1 && p <= 4) e_led = 4'd1 << col[s];
      end else if (k == 22) begin
        e_done = 1'b1;
      end
      tests++;
      if ({led, bus.o_busy, bus.o_done} !== {e_led, e_busy, e_done}) begin
        fails++;
        $display("FAIL play3 k=%0d led/busy/done got=%b/%b/%b exp=%b/%b/%b",
                 k, led, bus.o_busy, bus.o_done, e_led, e_busy, e_done);
      end
      if (k <= 21 && p == 0) begin
        tests++;
        if (bus.o_seq_addr !== 5'(s)) begin
          fails++; $display("FAIL play3_addr k=%0d got=%0d exp=%0d", k, bus.o_seq_addr, s);
        end
      end
      tick();
    end
  endtask

  task automatic test_len0();
    bus.i_start = 1'b1; bus.i_len = 6'd0;
    tick();
    bus.i_start = 1'b0;
    tests++;
    if ({led, bus.o_busy, bus.o_done} !== 6'b0000_01) begin
      fails++; $display("FAIL len0_t1 led/busy/done got=%b/%b/%b exp=0000/0/1", led, bus.o_busy, bus.o_done);
    end
    tick();
    tests++;
    if ({led, bus.o_busy, bus.o_done} !== 6'b0000_00) begin
      fails++; $display("FAIL len0_t2 led/busy/done got=%b/%b/%b exp=0000/0/0", led, bus.o_busy, bus.o_done);
    end
  endtask

  task automatic test_clamp();
    logic [3:0] e_led;
    logic       e_busy, e_done;
    int s, p;
    for (int i = 0; i < 32; i++) mem[i] = 2'((i * 3 + 1) % 4);
    bus.i_start = 1'b1; bus.i_len = 6'd40;
    tick();
    bus.i_start = 1'b0;
    for (int k = 1; k <= 227; k++) begin
      s = (k - 1) / 7; p = (k - 1) % 7;
      e_led = 4'd0; e_busy = 1'b0; e_done = 1'b0;
      if (k <= 224) begin
        e_busy = 1'b1;
        if (p >= 1 && p <= 4) e_led = 4'd1 << ((s * 3 + 1) % 4);
      end else if (k == 225) begin
        e_done = 1'b1;
      end
      tests++;
      if ({led, bus.o_busy, bus.o_done} !== {e_led, e_busy, e_done}) begin
        fails++;
        $display("FAIL clamp k=%0d led/busy/done got=%b/%b/%b exp=%b/%b/%b",
                 k, led, bus.o_busy, bus.o_done, e_led, e_busy, e_done);
      end
      if (k <= 224 && p == 0) begin
        tests++;
        if (bus.o_seq_addr !== 5'(s)) begin
          fails++; $display("FAIL clamp_addr k=%0d got=%0d exp=%0d", k, bus.o_seq_addr, s);
        end
      end
      tick();
    end
  endtask

  task automatic test_rst_mid();
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
    bus.i_start = 1'b1; bus.i_len = 6'd3;
    tick();
    bus.i_start = 1'b0;
    for (int k = 2; k <= 10; k++) tick();
    tests++; if (led !== 4'b0001) begin fails++; $display("FAIL rstmid_pre led got=%b exp=0001", led); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({led, bus.o_busy, bus.o_done, bus.o_seq_addr} !== 11'd0) begin
      fails++; $display("FAIL rstmid_post led/busy/done/addr got=%b/%b/%b/%0d exp=0000/0/0/0",
                        led, bus.o_busy, bus.o_done, bus.o_seq_addr);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      tests++;
      if ({bus.o_busy, bus.o_done, led} !== 6'd0) begin
        fails++; $display("FAIL rstmid_quiet k=%0d busy/done/led got=%b/%b/%b exp=0/0/0000",
                          k, bus.o_busy, bus.o_done, led);
      end
    end
    bus.i_start = 1'b1; bus.i_len = 6'd1;
    tick();
    bus.i_start = 1'b0;
    tests++;
    if (bus.o_busy !== 1'b1 || bus.o_seq_addr !== 5'd0) begin
      fails++; $display("FAIL restart_fetch busy/addr got=%b/%0d exp=1/0", bus.o_busy, bus.o_seq_addr);
    end
    tick();
    tests++; if (led !== 4'b0100) begin fails++; $display("FAIL restart_led got=%b exp=0100", led); end
    for (int k = 3; k <= 8; k++) tick();
    tests++; if (bus.o_done !== 1'b1) begin fails++; $display("FAIL restart_done got=%b exp=1", bus.o_done); end
  endtask

`ifdef GENIUS_LED_ECHO_EN
  task automatic test_echo();
    mem[0] = 2'd3;
    bus.i_btn1 = 1'b0;
    tick();
    bus.i_btn1 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tests++;
      if ({led, bus.o_busy} !== {(k <= 4) ? 4'b0010 : 4'b0000, 1'b0}) begin
        fails++; $display("FAIL echo k=%0d led/busy got=%b/%b", k, led, bus.o_busy);
      end
      tick();
    end
    bus.i_btn0 = 1'b0; bus.i_btn2 = 1'b0;
    tick();
    bus.i_btn0 = 1'b1; bus.i_btn2 = 1'b1;
    tests++; if (led !== 4'b0001) begin fails++; $display("FAIL echo_prio led got=%b exp=0001", led); end
    tick();
    bus.i_btn3 = 1'b0;
    tick();
    bus.i_btn3 = 1'b1;
    tests++; if (led !== 4'b1000) begin fails++; $display("FAIL echo_restart led got=%b exp=1000", led); end
    bus.i_start = 1'b1; bus.i_len = 6'd1;
    tick();
    bus.i_start = 1'b0;
    tests++;
    if ({led, bus.o_busy} !== 5'b0000_1) begin
      fails++; $display("FAIL echo_abort led/busy got=%b/%b exp=0000/1", led, bus.o_busy);
    end
    tick();
    tests++; if (led !== 4'b1000) begin fails++; $display("FAIL echo_play led got=%b exp=1000", led); end
    for (int k = 3; k <= 8; k++) tick();
    tests++; if (bus.o_done !== 1'b1) begin fails++; $display("FAIL echo_play_done got=%b exp=1", bus.o_done); end
  endtask
`else
  task automatic test_btn_ignored();
    bus.i_btn1 = 1'b0;
    tick();
    bus.i_btn1 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tests++;
      if ({led, bus.o_busy} !== 5'd0) begin
        fails++; $display("FAIL btn_ignored k=%0d led/busy got=%b/%b exp=0000/0", k, led, bus.o_busy);
      end
      tick();
    end
  endtask
`endif

  initial begin
    bus.i_start = 1'b0; bus.i_len = 6'd0;
    bus.i_btn0 = 1'b1; bus.i_btn1 = 1'b1; bus.i_btn2 = 1'b1; bus.i_btn3 = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 2'd0;
    test_reset();
    test_play3();
    test_len0();
    test_clamp();
    test_rst_mid();
    tick();
`ifdef GENIUS_LED_ECHO_EN
    test_echo();
`else
    test_btn_ignored();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
